// File: rtl/sdram_phase_autotune_pkg.sv
// Shared types and helpers for the SDRAM clock phase auto-tuner: FSM encodings,
// counter width derivation and the pass/fail judge over tester counter deltas.
package sdram_tune_pkg;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SETTLE      = 4'd1,
        S_DWELL_START = 4'd2,
        S_DWELL       = 4'd3,
        S_JUDGE       = 4'd4,
        S_STEP_PULSE  = 4'd5,
        S_STEP_GAP    = 4'd6,
        S_MOVE_PULSE  = 4'd7,
        S_MOVE_GAP    = 4'd8,
        S_FINISH      = 4'd9
    } tune_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } step_state_t;

    localparam int STATE_W = 4;

    // Width of a counter that must reach max(a, b) - 1, with one bit of headroom.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

    // Deltas are taken modulo 2^32 so counter wrap between snapshot and judge is harmless.
    function automatic logic judge_pass(input logic [31:0] pc_now, input logic [31:0] pc_snap,
                                        input logic [31:0] fc_now, input logic [31:0] fc_snap);
        return ((fc_now - fc_snap) == 32'd0) && ((pc_now - pc_snap) != 32'd0);
    endfunction

endpackage

// File: rtl/sdram_phase_autotune_phase_stepper.sv
// Produces one PLL phasestep pulse followed by a mandatory low gap per request.
// Handshake: i_req is sampled in ST_IDLE or on the last gap cycle; o_ack is high for
// exactly that last gap cycle, so a back-to-back request starts the next pulse without
// ever merging two pulses.
module phase_stepper
    import sdram_tune_pkg::*;
#(
    parameter int C_pulse_cycles = 4,
    parameter int C_gap_cycles   = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    output logic o_phasestep,
    output logic o_pulse_last,
    output logic o_ack
);

    localparam int SW = cnt_width(C_pulse_cycles, C_gap_cycles);
    localparam logic [SW-1:0] PULSE_LAST = SW'(C_pulse_cycles - 1);
    localparam logic [SW-1:0] GAP_LAST   = SW'(C_gap_cycles - 1);

    step_state_t     r_state;
    step_state_t     w_state_next;
    logic [SW-1:0]   r_cnt;
    logic            w_pulse_last;
    logic            w_gap_last;

    assign w_pulse_last = (r_state == ST_PULSE) && (r_cnt == PULSE_LAST);
    assign w_gap_last   = (r_state == ST_GAP) && (r_cnt == GAP_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + SW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_req) w_state_next = ST_PULSE;
            ST_PULSE: if (w_pulse_last) w_state_next = ST_GAP;
            ST_GAP:   if (w_gap_last) w_state_next = i_req ? ST_PULSE : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_phasestep  = (r_state == ST_PULSE);
        o_pulse_last = w_pulse_last;
        o_ack        = w_gap_last;
    end

endmodule

// File: rtl/sdram_phase_autotune.sv
// Sweeps the SDRAM chip clock phase through one rotation, judges each position from the
// memory tester counters, then steps forward to the centre of the longest passing window.
module sdram_phase_autotune
    import sdram_tune_pkg::*;
#(
    parameter int C_phase_steps   = 64,
    parameter int C_pulse_cycles  = 4,
    parameter int C_gap_cycles    = 4,
    parameter int C_settle_cycles = 1024,
    parameter int C_dwell_cycles  = 262144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] passcount,
    input  logic [31:0] failcount,
    output logic        tester_rst_n,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic [7:0]  phase,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  win_lo,
    output logic [7:0]  win_hi,
    output logic [7:0]  best,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int PW = $clog2(C_phase_steps);
    localparam int LW = PW + 1;
    localparam int CW = cnt_width(C_settle_cycles, C_dwell_cycles);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(C_settle_cycles - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(C_dwell_cycles - 1);
    localparam logic [PW-1:0] P_LAST      = PW'(C_phase_steps - 1);

    tune_state_t   r_state;
    tune_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] r_p;
    logic [31:0]   r_snap_p;
    logic [31:0]   r_snap_f;
    logic [LW-1:0] r_cur_len;
    logic [PW-1:0] r_cur_lo;
    logic [LW-1:0] r_best_len;
    logic [PW-1:0] r_win_lo;
    logic [PW-1:0] r_win_hi;
    logic [PW-1:0] r_best;
    logic [PW-1:0] r_moves;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_pulse_last;
    logic          w_ack;
    logic          w_step_req;
    logic          w_tester_rst_n;
    logic          w_pass;
    logic [LW-1:0] w_new_len;
    logic [PW-1:0] w_new_lo;
    logic [PW-1:0] w_best_calc;
    logic          w_last_pos;

    phase_stepper #(
        .C_pulse_cycles(C_pulse_cycles),
        .C_gap_cycles  (C_gap_cycles)
    ) u_stepper (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (w_step_req),
        .o_phasestep (phasestep),
        .o_pulse_last(w_pulse_last),
        .o_ack       (w_ack)
    );

    assign w_pass      = judge_pass(passcount, r_snap_p, failcount, r_snap_f);
    assign w_new_len   = w_pass ? r_cur_len + LW'(1) : '0;
    assign w_new_lo    = (w_pass && (r_cur_len == '0)) ? r_p : r_cur_lo;
    assign w_best_calc = r_win_lo + PW'((r_best_len - LW'(1)) >> 1);
    assign w_last_pos  = (r_p == P_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:        if (start) w_state_next = S_SETTLE;
            S_SETTLE:      if (r_cnt == SETTLE_LAST) w_state_next = S_DWELL_START;
            S_DWELL_START: w_state_next = S_DWELL;
            S_DWELL:       if (r_cnt == DWELL_LAST) w_state_next = S_JUDGE;
            S_JUDGE:       w_state_next = S_STEP_PULSE;
            S_STEP_PULSE:  if (w_pulse_last) w_state_next = S_STEP_GAP;
            S_STEP_GAP: begin
                if (w_ack) begin
                    if (!w_last_pos)                                   w_state_next = S_SETTLE;
                    else if (r_best_len == '0 || w_best_calc == '0)   w_state_next = S_FINISH;
                    else                                               w_state_next = S_MOVE_PULSE;
                end
            end
            S_MOVE_PULSE:  if (w_pulse_last) w_state_next = S_MOVE_GAP;
            S_MOVE_GAP:    if (w_ack) w_state_next = (r_moves == PW'(1)) ? S_FINISH : S_MOVE_PULSE;
            S_FINISH:      w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // The tester is held in reset whenever the clock phase is being disturbed.
    always_comb begin
        w_tester_rst_n = 1'b1;
        w_step_req     = 1'b0;
        case (r_state)
            S_SETTLE, S_STEP_PULSE, S_STEP_GAP, S_MOVE_PULSE, S_MOVE_GAP: w_tester_rst_n = 1'b0;
            default: w_tester_rst_n = 1'b1;
        endcase
        if ((w_state_next == S_STEP_PULSE && r_state != S_STEP_PULSE) ||
            (w_state_next == S_MOVE_PULSE && r_state != S_MOVE_PULSE))
            w_step_req = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_phase    <= '0;
            r_p        <= '0;
            r_snap_p   <= '0;
            r_snap_f   <= '0;
            r_cur_len  <= '0;
            r_cur_lo   <= '0;
            r_best_len <= '0;
            r_win_lo   <= '0;
            r_win_hi   <= '0;
            r_best     <= '0;
            r_moves    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + CW'(1);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_p        <= '0;
                        r_cur_len  <= '0;
                        r_cur_lo   <= '0;
                        r_best_len <= '0;
                        r_win_lo   <= '0;
                        r_win_hi   <= '0;
                        r_best     <= '0;
                    end
                end
                S_DWELL_START: begin
                    r_snap_p <= passcount;
                    r_snap_f <= failcount;
                end
                S_JUDGE: begin
                    r_cur_len <= w_new_len;
                    r_cur_lo  <= w_new_lo;
                    // Strict compare keeps the earliest of equally long runs.
                    if (w_new_len > r_best_len) begin
                        r_best_len <= w_new_len;
                        r_win_lo   <= w_new_lo;
                        r_win_hi   <= r_p;
                    end
                end
                S_STEP_GAP: begin
                    if (w_ack) begin
                        r_phase <= r_phase + PW'(1);
                        r_p     <= r_p + PW'(1);
                        if (w_last_pos) begin
                            if (r_best_len == '0) begin
                                r_error <= 1'b1;
                                r_best  <= '0;
                                r_moves <= '0;
                            end else begin
                                r_best  <= w_best_calc;
                                r_moves <= w_best_calc;
                            end
                        end
                    end
                end
                S_MOVE_GAP: begin
                    if (w_ack) begin
                        r_phase <= r_phase + PW'(1);
                        r_moves <= r_moves - PW'(1);
                    end
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tester_rst_n = w_tester_rst_n;
    assign phasedir     = 1'b0;
    assign phaseloadreg = 1'b0;
    assign phase        = 8'(r_phase);
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign win_lo       = 8'(r_win_lo);
    assign win_hi       = 8'(r_win_hi);
    assign best         = 8'(r_best);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_sdram_phase_autotune.sv
// Bench for sdram_phase_autotune with a phase-keyed behavioural memory tester and a
// scoreboard of expected sweep results.
module tb_sdram_phase_autotune;
    import sdram_tune_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] passcount;
    logic [31:0] failcount;
    logic        tester_rst_n, phasedir, phasestep, phaseloadreg;
    logic        busy, done, error;
    logic [7:0]  phase, win_lo, win_hi, best;
    logic [3:0]  dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sdram_phase_autotune #(
        .C_phase_steps  (N),
        .C_pulse_cycles (4),
        .C_gap_cycles   (4),
        .C_settle_cycles(8),
        .C_dwell_cycles (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .passcount   (passcount),
        .failcount   (failcount),
        .tester_rst_n(tester_rst_n),
        .phasedir    (phasedir),
        .phasestep   (phasestep),
        .phaseloadreg(phaseloadreg),
        .phase       (phase),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .win_lo      (win_lo),
        .win_hi      (win_hi),
        .best        (best),
        .dbg_state   (dbg_state)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [15:0] pass_mask = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural tester ----------------
    always @(negedge clk) begin
        if (!reset && busy && tester_rst_n) begin
            if (pass_mask[phase[3:0]]) passcount = passcount + 32'd1;
            else                       failcount = failcount + 32'd1;
        end
    end

    // ---------------- pulse / reset-window monitor ----------------
    int   mon_pulses = 0;
    int   mon_viol   = 0;
    int   hi_len     = 0;
    int   gap_len    = 100;
    logic prev_ps    = 1'b0;
    logic rst_hi     = 1'b0;

    always @(negedge clk) begin
        if (!reset && tester_rst_n &&
            (dbg_state == S_SETTLE || dbg_state == S_STEP_PULSE || dbg_state == S_STEP_GAP))
            mon_viol++;
        if (phasestep) begin
            if (!prev_ps) begin
                check("gap", 32'(gap_len >= 4), 32'd1);
                mon_pulses++;
                hi_len = 0;
                rst_hi = 1'b0;
            end
            hi_len++;
            if (tester_rst_n) rst_hi = 1'b1;
        end else begin
            if (prev_ps) begin
                check("pulse_w", 32'(hi_len), 32'd4);
                check("rst_in_pulse", 32'(rst_hi), 32'd0);
                check("dir_load", {30'd0, phasedir, phaseloadreg}, 32'd0);
                gap_len = 0;
            end
            gap_len++;
        end
        prev_ps = phasestep;
    end

    // ---------------- reference window model ----------------
    function automatic void ref_window(input logic [15:0] m, output int lo, output int hi, output int len);
        bit ok;
        lo = 0; hi = 0; len = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = a; b < N; b++) begin
                ok = 1'b1;
                for (int k = a; k <= b; k++) if (!m[k]) ok = 1'b0;
                if (ok && (b - a + 1) > len) begin
                    lo = a; hi = b; len = b - a + 1;
                end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ctl", {25'd0, busy, done, error, tester_rst_n, phasestep, phasedir, phaseloadreg},
              32'b0001000);
        check("reset_idx", {phase, win_lo, win_hi, best}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dwell(input int min_pulses, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dbg_state == S_DWELL && (mon_pulses - base) >= min_pulses) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_sweep(input logic [15:0] m, input logic [31:0] pc0, input logic [31:0] fc0,
                             input bit rst_first, input int restart_at);
        int lo, hi, len, exp_best, base, vbase;
        bit ok;
        if (rst_first) do_reset();
        pass_mask = m;
        passcount = pc0;
        failcount = fc0;
        ref_window(m, lo, hi, len);
        exp_best = (len > 0) ? lo + (len - 1) / 2 : 0;
        exp_q.push_back(32'(lo));
        exp_q.push_back(32'(hi));
        exp_q.push_back(32'(exp_best));
        exp_q.push_back(32'(exp_best));
        exp_q.push_back(32'(len == 0));
        exp_q.push_back(32'(N + exp_best));
        base  = mon_pulses;
        vbase = mon_viol;
        pulse_start();
        check("busy_on_start", 32'(busy), 32'd1);
        if (restart_at >= 0) begin
            wait_dwell(restart_at, base, ok);
            check("reach_dwell", 32'(ok), 32'd1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_restart", 32'(busy), 32'd1);
        end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
        check("win_lo", 32'(win_lo), exp_q.pop_front());
        check("win_hi", 32'(win_hi), exp_q.pop_front());
        check("best", 32'(best), exp_q.pop_front());
        check("phase", 32'(phase), exp_q.pop_front());
        check("error", 32'(error), exp_q.pop_front());
        check("pulses", 32'(mon_pulses - base), exp_q.pop_front());
        check("busy_end", 32'(busy), 32'd0);
        check("rst_n_end", 32'(tester_rst_n), 32'd1);
        check("rst_window", 32'(mon_viol - vbase), 32'd0);
    endtask

    task automatic abort_test();
        int  base;
        bit  ok;
        do_reset();
        pass_mask = 16'h07E0;
        passcount = '0;
        failcount = '0;
        base = mon_pulses;
        pulse_start();
        wait_dwell(3, base, ok);
        check("reach_dwell_abort", 32'(ok), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rst_n", 32'(tester_rst_n), 32'd1);
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_step", 32'(phasestep), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sweep(16'h07E0, 32'd0, 32'd0, 1'b0, -1);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        passcount = '0;
        failcount = '0;

        check("judge_wrap", 32'(judge_pass(32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 32'd1);
        check("judge_nopass", 32'(judge_pass(32'h1234_5678, 32'h1234_5678, 32'd7, 32'd7)), 32'd0);
        check("judge_fail", 32'(judge_pass(32'd9, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF)), 32'd0);

        run_sweep(16'h07E0, 32'd0, 32'd0, 1'b1, -1);
        run_sweep(16'h1F0C, 32'd0, 32'd0, 1'b1, -1);
        run_sweep(16'h0E0E, 32'd0, 32'd0, 1'b1, -1);
        run_sweep(16'h0000, 32'd0, 32'd0, 1'b1, -1);
        run_sweep(16'hFFFF, 32'd0, 32'd0, 1'b1, -1);
        run_sweep(16'hFFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, -1);
        run_sweep(16'h07E0, 32'd0, 32'd0, 1'b1, 4);
        abort_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_phase_autotune.md
Name: sdram_phase_autotune

Overview:
- Sequencer that sweeps the dynamic phase of the SDRAM chip clock output (PLL out1) through one full rotation.
- At each phase position it gates the memory tester and judges pass/fail from the tester's passcount/failcount deltas.
- It finds the longest contiguous passing window and finally steps the PLL to the window centre.
- Replaces manual button tuning. Sits between mem_tester counters and the PLL phasesel/phasedir/phasestep/phaseloadreg pins, in the clk_sdram domain.

Parameters:
- C_phase_steps, 64, phase steps per full 360 deg rotation (power of 2, 4..256).
- C_pulse_cycles, 4, cycles phasestep is held high per step.
- C_gap_cycles, 4, low cycles after each pulse before the next action.
- C_settle_cycles, 1024, cycles tester held in reset after a step.
- C_dwell_cycles, 262144, observation window per position with tester running.

Ports:
- clk  in  1  clk_sdram; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins sweep when idle.
- passcount  in  32  mem_tester pass counter.
- failcount  in  32  mem_tester fail counter.
- tester_rst_n  out  1  active-low reset to mem_tester, ANDed externally with lock/DIP.
- phasedir  out  1  PLL phase direction; always 0 (forward).
- phasestep  out  1  PLL phase step pulse.
- phaseloadreg  out  1  tied 0.
- phase  out  8  current relative phase index modulo C_phase_steps (0 at reset).
- busy  out  1  sweep or final move in progress.
- done  out  1  sticky; set at completion, cleared by next accepted start.
- error  out  1  sticky; no passing position found.
- win_lo, win_hi, best  out  8 each  chosen window bounds and target index.

Behaviour:
- Reset values: tester_rst_n=1, phasestep=0, phasedir=0, phaseloadreg=0, phase=0, busy=0, done=0, error=0, win_lo=win_hi=best=0, FSM=IDLE.
- Reset mid-operation aborts immediately to these values. PLL physical phase is NOT restored; phase 0 redefines the origin.
- States: IDLE, SETTLE, DWELL_START, DWELL, JUDGE, STEP_PULSE, STEP_GAP, MOVE_PULSE, MOVE_GAP, FINISH.
- IDLE: start=1 -> SETTLE. Clears done/error, run trackers and position counter p=0; busy=1 from the next cycle. start while busy is ignored.
- SETTLE: tester_rst_n=0 for C_settle_cycles, then -> DWELL_START.
- DWELL_START (1 cycle): tester_rst_n=1; snapshot passcount and failcount.
- DWELL: C_dwell_cycles, tester_rst_n=1.
- JUDGE (1 cycle): pass iff (failcount - snap_f) mod 2^32 == 0 AND (passcount - snap_p) mod 2^32 != 0.
- Run tracking, linear over p=0..N-1, no wrap-around join:
  - On pass: cur_len++, and cur_lo=p if cur_len was 0.
  - On fail: cur_len=0.
  - If the updated cur_len > best_len (strict, so the earliest longest run wins): best_len=cur_len, win_lo=cur_lo, win_hi=p.
  - Then -> STEP_PULSE.
- STEP_PULSE: phasestep=1 for C_pulse_cycles, tester_rst_n=0. Then -> STEP_GAP (phasestep=0, C_gap_cycles). On exit phase=phase+1 mod N and p++.
  - If p was N-1: the rotation is complete (phase back to 0) -> FINISH-prep. Else -> SETTLE.
- After sweep:
  - If best_len=0: error=1, best=0, go FINISH.
  - Else best = win_lo + ((best_len-1)>>1), then issue best forward steps via MOVE_PULSE/MOVE_GAP (same timing). phase increments per step.
- FINISH: tester_rst_n=1, busy=0, done=1 -> IDLE.
- Totals: forward step pulses = N + best. phasedir never 1. phasestep is never high in two consecutive step slots without a gap.
- Width: internal counters sized by $clog2 of each parameter; phase/win/best zero-extended to 8 bits.

Decomposition:
- Package sdram_tune_pkg: FSM state enum, pass-judge function (modular delta), width constants derived from parameters.
- Sub-module phase_stepper: accepts req, produces one phasestep pulse plus gap, returns ack. Shared by sweep and move phases.
- Top module holds FSM and run tracker.

Test Plan (N=16, pulse 4, gap 4, settle 8, dwell 64, behavioural tester model keyed on phase):
- Pass at positions 5..10 only -> win_lo=5, win_hi=10, best=7, 23 phasestep pulses, final phase=7, done=1, error=0.
- Passing runs 2..3 and 8..12 -> win_lo=8, win_hi=12, best=10. Equal runs 1..3 and 9..11 -> earliest wins: win_lo=1, best=2.
- All fail -> error=1, done=1, best=0, exactly 16 pulses, phase=0.
- All pass -> win_lo=0, win_hi=15, best=7. Separately, failcount snapshot 0xFFFFFFFF unchanged with passcount wrapping 0xFFFFFFFF->0x00000002 is judged pass.
- start re-pulsed during DWELL -> ignored, sweep unchanged. Assert reset mid-DWELL -> same cycle busy=0, tester_rst_n=1, phase=0, phasestep=0; a later start runs a clean sweep.
- Check tester_rst_n=0 throughout every SETTLE and STEP window and phasestep high exactly 4 cycles per pulse.
